// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Updates go through one staging register and are forwarded to same-index predictions.
module branch_target_predictor #(
   parameter int IDX_W = 6,
   parameter int CNT_W = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] pc_i,
   output logic        pred_hit_o,
   output logic        pred_taken_o,
   output logic [31:0] pred_next_pc_o,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic        upd_taken_i,
   input  logic [31:0] upd_target_i
);

   localparam int DEPTH = 2 ** IDX_W;
   localparam int TAG_W = 30 - IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] WEAK_T   = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] WEAK_NT  = {1'b0, {(CNT_W-1){1'b1}}};

   logic             valid_r  [DEPTH];
   logic [TAG_W-1:0] tag_r    [DEPTH];
   logic [31:0]      target_r [DEPTH];
   logic [CNT_W-1:0] cnt_r    [DEPTH];

   logic        stg_valid_r;
   logic [29:0] stg_pc_r;
   logic        stg_taken_r;
   logic [31:0] stg_target_r;

   logic [IDX_W-1:0] stg_idx_s;
   logic [TAG_W-1:0] stg_tag_s;
   logic             base_hit_s;
   logic             res_valid_s;
   logic [TAG_W-1:0] res_tag_s;
   logic [31:0]      res_target_s;
   logic [CNT_W-1:0] res_cnt_s;

   logic [IDX_W-1:0] idx_s;
   logic [TAG_W-1:0] tag_s;
   logic             fwd_s;
   logic             e_valid_s;
   logic [TAG_W-1:0] e_tag_s;
   logic [31:0]      e_target_s;
   logic [CNT_W-1:0] e_cnt_s;
   logic             unused_pc_bits_s;

   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic taken);
      if (taken) begin
         if (cnt == CNT_MAX) return cnt;
         else                return cnt + CNT_ONE;
      end else begin
         if (cnt == CNT_ZERO) return cnt;
         else                 return cnt - CNT_ONE;
      end
   endfunction

   assign stg_idx_s        = stg_pc_r[IDX_W-1:0];
   assign stg_tag_s        = stg_pc_r[29:IDX_W];
   assign idx_s            = pc_i[IDX_W+1:2];
   assign tag_s            = pc_i[31:IDX_W+2];
   assign unused_pc_bits_s = ^{pc_i[1:0], upd_pc_i[1:0]};

   // Entry the staged update will produce, built from the live table so chained updates compose
   always_comb begin
      base_hit_s   = valid_r[stg_idx_s] && (tag_r[stg_idx_s] == stg_tag_s);
      res_valid_s  = valid_r[stg_idx_s];
      res_tag_s    = tag_r[stg_idx_s];
      res_target_s = target_r[stg_idx_s];
      res_cnt_s    = cnt_r[stg_idx_s];
      if (base_hit_s) begin
         res_cnt_s = cnt_next(cnt_r[stg_idx_s], stg_taken_r);
         if (stg_taken_r) res_target_s = stg_target_r;
         else             res_target_s = target_r[stg_idx_s];
      end else if (stg_taken_r) begin
         res_valid_s  = 1'b1;
         res_tag_s    = stg_tag_s;
         res_target_s = stg_target_r;
         res_cnt_s    = WEAK_T;
      end else begin
         res_valid_s  = valid_r[stg_idx_s];
         res_tag_s    = tag_r[stg_idx_s];
      end
   end

   // Prediction lookup, forwarding the pending staged result for a matching index
   always_comb begin
      fwd_s = stg_valid_r && (idx_s == stg_idx_s);
      if (fwd_s) begin
         e_valid_s  = res_valid_s;
         e_tag_s    = res_tag_s;
         e_target_s = res_target_s;
         e_cnt_s    = res_cnt_s;
      end else begin
         e_valid_s  = valid_r[idx_s];
         e_tag_s    = tag_r[idx_s];
         e_target_s = target_r[idx_s];
         e_cnt_s    = cnt_r[idx_s];
      end
      pred_hit_o   = e_valid_s && (e_tag_s == tag_s);
      pred_taken_o = pred_hit_o && e_cnt_s[CNT_W-1];
      if (pred_taken_o) pred_next_pc_o = e_target_s;
      else              pred_next_pc_o = pc_i + 32'd4;
   end

   // Staging register: captures one resolved branch per cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stg_valid_r  <= 1'b0;
         stg_pc_r     <= 30'd0;
         stg_taken_r  <= 1'b0;
         stg_target_r <= 32'd0;
      end else begin
         stg_valid_r <= upd_valid_i;
         if (upd_valid_i) begin
            stg_pc_r     <= upd_pc_i[31:2];
            stg_taken_r  <= upd_taken_i;
            stg_target_r <= upd_target_i;
         end
      end
   end

   // Table write-back of the staged result; reset discards anything pending
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_r[i]  <= 1'b0;
            tag_r[i]    <= {TAG_W{1'b0}};
            target_r[i] <= 32'd0;
            cnt_r[i]    <= WEAK_NT;
         end
      end else if (stg_valid_r) begin
         valid_r[stg_idx_s]  <= res_valid_s;
         tag_r[stg_idx_s]    <= res_tag_s;
         target_r[stg_idx_s] <= res_target_s;
         cnt_r[stg_idx_s]    <= res_cnt_s;
      end
   end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: directed scenarios plus randomized updates against a table model.
module tb_branch_target_predictor;

   localparam int IDX_W = 6;
   localparam int CNT_W = 2;
   localparam int DEPTH = 2 ** IDX_W;
   localparam int CMAX  = 2 ** CNT_W - 1;
   localparam int CTHR  = 2 ** (CNT_W - 1);

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [31:0] pc_i = 32'h0000_0100;
   logic        pred_hit_o;
   logic        pred_taken_o;
   logic [31:0] pred_next_pc_o;
   logic        upd_valid_i = 1'b0;
   logic [31:0] upd_pc_i = 32'd0;
   logic        upd_taken_i = 1'b0;
   logic [31:0] upd_target_i = 32'd0;

   int n_checks = 0;
   int n_pass = 0;

   bit          m_valid [DEPTH];
   int unsigned m_tag   [DEPTH];
   logic [31:0] m_tgt   [DEPTH];
   int          m_cnt   [DEPTH];

   branch_target_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .pc_i(pc_i),
      .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_next_pc_o(pred_next_pc_o),
      .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
      .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
         m_tgt[i]   = 32'd0;
         m_cnt[i]   = CTHR - 1;
      end
   endtask

   task automatic model_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      int unsigned i;
      int unsigned t;
      i = (pc >> 2) % DEPTH;
      t = pc >> (IDX_W + 2);
      if (m_valid[i] && m_tag[i] == t) begin
         if (taken) begin
            m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
            m_tgt[i] = tgt;
         end else begin
            m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
         end
      end else if (taken) begin
         m_valid[i] = 1'b1;
         m_tag[i]   = t;
         m_tgt[i]   = tgt;
         m_cnt[i]   = CTHR;
      end
   endtask

   task automatic check_pred(input string name, input logic [31:0] pc);
      int unsigned i;
      bit          e_hit;
      bit          e_tk;
      logic [31:0] e_nxt;
      i     = (pc >> 2) % DEPTH;
      e_hit = m_valid[i] && (m_tag[i] == (pc >> (IDX_W + 2)));
      e_tk  = e_hit && (m_cnt[i] >= CTHR);
      e_nxt = e_tk ? m_tgt[i] : pc + 32'd4;
      chk({name, ".hit"},   {31'd0, pred_hit_o},   {31'd0, e_hit});
      chk({name, ".taken"}, {31'd0, pred_taken_o}, {31'd0, e_tk});
      chk({name, ".next"},  pred_next_pc_o,        e_nxt);
   endtask

   // One cycle: drive inputs at the falling edge, check the prediction, then let the edge update
   task automatic step(input string name, input logic v, input logic [31:0] upc,
                       input logic t, input logic [31:0] tgt, input logic [31:0] ppc);
      upd_valid_i  = v;
      upd_pc_i     = upc;
      upd_taken_i  = t;
      upd_target_i = tgt;
      pc_i         = ppc;
      #1;
      check_pred(name, ppc);
      @(posedge clk_i);
      if (v && rst_ni) model_update(upc, t, tgt);
      @(negedge clk_i);
   endtask

   initial begin
      logic [31:0] rpc;
      logic [31:0] qpc;
      model_reset();
      #1;
      check_pred("in_reset", 32'h0000_0100);
      chk("in_reset.next_const", pred_next_pc_o, 32'h0000_0104);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;

      step("post_reset", 1'b0, 32'd0, 1'b0, 32'd0, 32'h0000_0100);
      chk("post_reset.next_const", pred_next_pc_o, 32'h0000_0104);

      step("alloc", 1'b1, 32'h100, 1'b1, 32'h200, 32'h100);
      step("alloc_fwd", 1'b0, 32'd0, 1'b0, 32'd0, 32'h100);
      step("alloc_tbl", 1'b0, 32'd0, 1'b0, 32'd0, 32'h100);
      chk("alloc.next_const", pred_next_pc_o, 32'h0000_0200);

      for (int k = 0; k < 3; k++) step("nt_run", 1'b1, 32'h100, 1'b0, 32'h0, 32'h100);
      step("nt_done", 1'b0, 32'd0, 1'b0, 32'd0, 32'h100);
      chk("nt_done.next_const", pred_next_pc_o, 32'h0000_0104);

      for (int k = 0; k < 4; k++) step("t_run", 1'b1, 32'h100, 1'b1, 32'h200, 32'h100);
      step("t_sat", 1'b1, 32'h100, 1'b0, 32'h0, 32'h100);
      step("t_sat_nt", 1'b0, 32'd0, 1'b0, 32'd0, 32'h100);
      chk("t_sat_nt.taken_const", {31'd0, pred_taken_o}, 32'd1);

      step("alias_a", 1'b1, 32'h100, 1'b1, 32'h200, 32'h100);
      step("alias_b", 1'b1, 32'h100 + (32'd4 << IDX_W), 1'b1, 32'h300, 32'h100);
      step("alias_old", 1'b0, 32'd0, 1'b0, 32'd0, 32'h100);
      step("alias_new", 1'b0, 32'd0, 1'b0, 32'd0, 32'h100 + (32'd4 << IDX_W));
      chk("alias_new.next_const", pred_next_pc_o, 32'h0000_0300);

      step("rst_stage", 1'b1, 32'h500, 1'b1, 32'h900, 32'h100);
      rst_ni = 1'b0;
      model_reset();
      pc_i = 32'h500;
      #1;
      check_pred("rst_pulse", 32'h500);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step("rst_first", 1'b1, 32'h600, 1'b1, 32'hA00, 32'h100);
      chk("rst_first.hit_const", {31'd0, pred_hit_o}, 32'd0);
      step("rst_cap", 1'b0, 32'd0, 1'b0, 32'd0, 32'h600);
      step("rst_lost", 1'b0, 32'd0, 1'b0, 32'd0, 32'h500);

      for (int k = 0; k < 400; k++) begin
         rpc = 32'h1000 + ($urandom_range(0, 1) << (IDX_W + 2)) + ($urandom_range(0, 3) << 2);
         if ($urandom_range(0, 3) == 0) qpc = $urandom;
         else qpc = 32'h1000 + ($urandom_range(0, 1) << (IDX_W + 2)) + ($urandom_range(0, 3) << 2);
         step("rand", ($urandom_range(0, 9) < 7), rpc, ($urandom_range(0, 9) < 6), $urandom, qpc);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
